// File: rtl/seq_mag_mult.sv
// rtl/seq_mag_mult.sv - shift-add sign/magnitude multiplier, 2*WIDTH-bit signed product
// Optional EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module seq_mag_mult #(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mag_a,
   input  logic [WIDTH-1:0]   mag_b,
   input  logic               neg_a,
   input  logic               neg_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    a_sh_q, a_sh_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    product_q, product_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             run_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_sh_q    <= '0;
         acc_q     <= '0;
         product_q <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         sgn_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         sgn_q     <= sgn_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      acc_d     = acc_q;
      product_d = product_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      run_last  = 1'b0;

      case (state_q)
         // DONE accepts a new request exactly like IDLE so starts can stream back-to-back
         S_IDLE, S_DONE: begin
            if (start) begin
               a_sh_d  = {{WIDTH{1'b0}}, mag_a};
               b_d     = mag_b;
               sgn_d   = neg_a ^ neg_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (b_q[0]) begin
               acc_d = acc_q + a_sh_q;
            end
            a_sh_d = a_sh_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
`ifdef EARLY_TERM_EN
            run_last = (cnt_q == CW'(WIDTH - 1)) || (b_d == '0);
`else
            run_last = (cnt_q == CW'(WIDTH - 1));
`endif
            if (run_last) begin
               state_d = S_FIX;
            end
         end
         // Negating a zero accumulator wraps back to zero, so no negative zero appears
         S_FIX: begin
            product_d = sgn_q ? (~acc_q + PW'(1)) : acc_q;
            state_d   = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_mag_mult.sv
// tb/tb_seq_mag_mult.sv - scoreboard bench for seq_mag_mult (WIDTH=5)
module tb_seq_mag_mult;

   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   mag_a = '0;
   logic [W-1:0]   mag_b = '0;
   logic           neg_a = 1'b0;
   logic           neg_b = 1'b0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [2*W-1:0] last_prod = '0;

   seq_mag_mult #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mag_a(mag_a), .mag_b(mag_b), .neg_a(neg_a), .neg_b(neg_b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
      int h = 0;
      for (int i = 0; i < W; i++) if (b[i]) h = i;
      return h + 2;
`else
      return W + 1;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", 32'(product), 32'(e.prod));
            check("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic push_exp(input logic [2*W-1:0] p, input int c);
      exp_t e;
      e.prod = p;
      e.cyc  = c;
      sb.push_back(e);
      last_prod = p;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain_timeout", 32'(sb.size()), 0);
         sb.delete();
      end
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic na, input logic [W-1:0] b,
                        input logic nb, input logic [2*W-1:0] p);
      @(negedge clk);
      mag_a = a; neg_a = na; mag_b = b; neg_b = nb; start = 1'b1;
      push_exp(p, cyc + 1 + lat(b));
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 1);
      mag_a = ~a; mag_b = ~b; neg_a = ~na; neg_b = ~nb;
   endtask

   initial begin
      int e0;
      int d1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_product", 32'(product), 0);
      rst = 1'b0;

      issue(5'd3, 1'b0, 5'd5, 1'b0, 10'h00F); drain();
      issue(5'd3, 1'b1, 5'd5, 1'b0, 10'h3F1); drain();
      issue(5'd16, 1'b1, 5'd16, 1'b1, 10'h100); drain();
      issue(5'd0, 1'b1, 5'd7, 1'b0, 10'h000); drain();
      issue(5'd31, 1'b0, 5'd31, 1'b1, 10'h03F); drain();
      issue(5'd31, 1'b0, 5'd31, 1'b0, 10'h3C1); drain();
      issue(5'd1, 1'b1, 5'd1, 1'b0, 10'h3FF); drain();
      issue(5'd16, 1'b0, 5'd16, 1'b1, 10'h300); drain();
      issue(5'd9, 1'b0, 5'd1, 1'b0, 10'h009); drain();
      issue(5'd3, 1'b0, 5'd16, 1'b0, 10'h030); drain();
      issue(5'd5, 1'b1, 5'd0, 1'b0, 10'h000); drain();
      issue(5'd6, 1'b0, 5'd6, 1'b1, 10'h3DC); drain();
      repeat (3) @(negedge clk);
      check("product_hold", 32'(product), 32'(last_prod));

      // Re-start at E3 while busy must be ignored
      issue(5'd3, 1'b0, 5'd5, 1'b0, 10'h00F);
      @(negedge clk);
      mag_a = 5'd7; mag_b = 5'd7; neg_a = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset in the middle of an operation discards it
      issue(5'd5, 1'b0, 5'd5, 1'b0, 10'h019);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_product", 32'(product), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_busy", 32'(busy), 0);

      // Start held high across DONE streams a second operation
      @(negedge clk);
      mag_a = 5'd2; neg_a = 1'b0; mag_b = 5'd3; neg_b = 1'b0; start = 1'b1;
      e0 = cyc + 1;
      d1 = e0 + lat(5'd3);
      push_exp(10'h006, d1);
      @(negedge clk);
      mag_a = 5'd4; neg_a = 1'b1; mag_b = 5'd5; neg_b = 1'b0;
      push_exp(10'h3EC, d1 + 1 + lat(5'd5));
      for (int i = 0; i < 40 && cyc < d1 + 1; i++) @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 1);
      drain();

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
